// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared types for the multi-cycle RISC-V sequencer: state encoding and
// watchdog counter width.
package riscv_mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERR    = 3'd7
  } mc_state_e;

  // Wide enough for any MEM_TIMEOUT up to 2^16-1.
  localparam int unsigned WAIT_W = 16;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl_wait_timer.sv
// Watchdog for memory handshakes: counts cycles spent waiting for an ack and
// flags the cycle in which the LIMIT-th unacknowledged cycle is reached.
module riscv_mc_ctrl_wait_timer
  import riscv_mc_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(LIMIT - 1);

  logic [WAIT_W-1:0] count;

  // Gated by enable so an ack arriving in the limit cycle wins.
  assign timeout = enable && (count == LAST);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + WAIT_W'(1);
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack handshakes to
// instruction and data memory, watchdog, and retire/cycle counters.
module riscv_mc_ctrl
  import riscv_mc_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       MEM_TIMEOUT = 255,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ack_i,
  input  logic [DATA_W-1:0] inst_rdata_i,
  output logic              data_req_o,
  output logic              data_we_o,
  input  logic              data_ack_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic              rd_we_i,
  input  logic [4:0]        rd_idx_i,
  input  logic [ADDR_W-1:0] pc_next_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] ir_o,
  output logic [DATA_W-1:0] mdr_o,
  output logic              rf_we_o,
  output logic [2:0]        state_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  instret_o,
  output logic [CNT_W-1:0]  mcycle_o
);

  mc_state_e state;
  logic      data_we_q;
  logic      waiting;
  logic      acked;
  logic      timeout;
  logic      wb_ok;
  logic      wb_write;

  assign waiting  = (state == ST_FETCH) || (state == ST_MEM);
  assign acked    = ((state == ST_FETCH) && inst_ack_i) || ((state == ST_MEM) && data_ack_i);
  assign wb_ok    = word_aligned(pc_next_i[1:0]);
  assign wb_write = rd_we_i && (rd_idx_i != 5'd0) && wb_ok;

  // The state register rests in FETCH while reset is held, so the fetch
  // request is masked by rst to keep it low during reset.
  assign inst_req_o  = rst && (state == ST_FETCH);
  assign inst_addr_o = pc_o;
  assign data_req_o  = (state == ST_MEM);
  assign data_we_o   = data_we_q;
  assign state_o     = state;

  // FETCH and MEM never overlap, so one watchdog serves both.
  riscv_mc_ctrl_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!waiting || acked),
    .enable (waiting && !acked),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: ir_o/mdr_o are plain registers, not arrays, so resetting them is cheap and gives a known value.
      state     <= ST_FETCH;
      pc_o      <= RESET_PC;
      ir_o      <= '0;
      mdr_o     <= '0;
      data_we_q <= 1'b0;
      rf_we_o   <= 1'b0;
      err_o     <= 1'b0;
      instret_o <= '0;
      mcycle_o  <= '0;
    end else begin
      rf_we_o <= 1'b0;
      if (state != ST_ERR) mcycle_o <= mcycle_o + CNT_W'(1);

      unique case (state)
        ST_FETCH: begin
          if (inst_ack_i) begin
            ir_o  <= inst_rdata_i;
            state <= ST_DECODE;
          end else if (timeout) begin
            state <= ST_ERR;
            err_o <= 1'b1;
          end
        end
        ST_DECODE: state <= ST_EXEC;
        ST_EXEC: begin
          if (is_load_i || is_store_i) begin
            data_we_q <= is_store_i;
            state     <= ST_MEM;
          end else begin
            rf_we_o <= wb_write;
            state   <= ST_WB;
          end
        end
        ST_MEM: begin
          if (data_ack_i) begin
            if (!data_we_q) mdr_o <= data_rdata_i;
            data_we_q <= 1'b0;
            rf_we_o   <= wb_write;
            state     <= ST_WB;
          end else if (timeout) begin
            data_we_q <= 1'b0;
            err_o     <= 1'b1;
            state     <= ST_ERR;
          end
        end
        ST_WB: begin
          // rf_we_o was raised on entry to WB and is already gated by wb_ok.
          if (wb_ok) begin
            pc_o      <= pc_next_i;
            instret_o <= instret_o + CNT_W'(1);
            state     <= ST_FETCH;
          end else begin
            err_o <= 1'b1;
            state <= ST_ERR;
          end
        end
        ST_ERR: state <= ST_ERR;
        default: begin
          err_o <= 1'b1;
          state <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: directed vector table, reset and
// timeout sequences, then randomized instructions against a cycle-count model.
module tb_riscv_mc_ctrl;

  localparam int          TIMEOUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i;
  logic [31:0] inst_rdata_i;
  logic        data_req_o;
  logic        data_we_o;
  logic        data_ack_i;
  logic [31:0] data_rdata_i;
  logic        is_load_i;
  logic        is_store_i;
  logic        rd_we_i;
  logic [4:0]  rd_idx_i;
  logic [31:0] pc_next_i;
  logic [31:0] pc_o;
  logic [31:0] ir_o;
  logic [31:0] mdr_o;
  logic        rf_we_o;
  logic [2:0]  state_o;
  logic        err_o;
  logic [31:0] instret_o;
  logic [31:0] mcycle_o;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(RESET_PC), .MEM_TIMEOUT(TIMEOUT), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o), .inst_ack_i(inst_ack_i),
    .inst_rdata_i(inst_rdata_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_ack_i(data_ack_i),
    .data_rdata_i(data_rdata_i),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .rd_we_i(rd_we_i), .rd_idx_i(rd_idx_i),
    .pc_next_i(pc_next_i),
    .pc_o(pc_o), .ir_o(ir_o), .mdr_o(mdr_o), .rf_we_o(rf_we_o), .state_o(state_o),
    .err_o(err_o), .instret_o(instret_o), .mcycle_o(mcycle_o)
  );

  typedef struct {
    logic        is_load;
    logic        is_store;
    logic        rd_we;
    logic [4:0]  rd_idx;
    logic [31:0] pc_next;
    logic [31:0] inst;
    logic [31:0] rdata;
    int          inst_wait;   // unacked FETCH cycles before the ack
    int          data_wait;   // unacked MEM cycles before the ack
    int          exp_cycles;  // clocks until back in FETCH, or until entering ERR
    int          exp_mem;     // cycles with data_req_o high
    int          exp_rf_we;   // rf_we_o pulses
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Architectural model state.
  logic [31:0] m_pc, m_instret, m_mcycle, m_ir, m_mdr;
  logic [2:0]  trace[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic we, input logic [4:0] rd,
                              input logic [31:0] pcn, input int iw, input int dw, input logic [31:0] rdata,
                              input int cyc, input int mem, input int rfw, input logic err);
    vec_t v;
    v.is_load = ld; v.is_store = st; v.rd_we = we; v.rd_idx = rd;
    v.pc_next = pcn; v.inst = 32'hA500_0000 ^ pcn; v.rdata = rdata;
    v.inst_wait = iw; v.data_wait = dw;
    v.exp_cycles = cyc; v.exp_mem = mem; v.exp_rf_we = rfw; v.exp_err = err;
    return v;
  endfunction

  // Timing model built from the phase budget: fetch wait, decode, exec, mem wait, writeback.
  function automatic vec_t predict(input vec_t v);
    v.exp_mem = 0; v.exp_rf_we = 0; v.exp_err = 1'b0;
    if (v.inst_wait >= TIMEOUT) begin
      v.exp_cycles = TIMEOUT; v.exp_err = 1'b1;
      return v;
    end
    v.exp_cycles = v.inst_wait + 1 + 2;
    if (v.is_load || v.is_store) begin
      if (v.data_wait >= TIMEOUT) begin
        v.exp_cycles += TIMEOUT; v.exp_mem = TIMEOUT; v.exp_err = 1'b1;
        return v;
      end
      v.exp_cycles += v.data_wait + 1;
      v.exp_mem = v.data_wait + 1;
    end
    v.exp_cycles += 1;
    if (v.pc_next[1:0] != 2'b00) v.exp_err = 1'b1;
    else v.exp_rf_we = (v.rd_we && v.rd_idx != 5'd0) ? 1 : 0;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b0; inst_ack_i = 1'b0; data_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.state",   state_o,    3'd0);
    check("rst.pc",      pc_o,       RESET_PC);
    check("rst.ir",      ir_o,       32'd0);
    check("rst.mdr",     mdr_o,      32'd0);
    check("rst.reqs",    {inst_req_o, data_req_o, data_we_o, rf_we_o, err_o}, 5'd0);
    check("rst.counts",  {instret_o, mcycle_o}, 64'd0);
    m_pc = RESET_PC; m_instret = '0; m_mcycle = '0; m_ir = '0; m_mdr = '0;
    rst = 1'b1;
    #1;
  endtask

  // Starts at a sampling point with the DUT in FETCH; drives handshakes for the
  // predicted number of cycles, then compares against the model.
  task automatic run_vec(input vec_t v, input int id);
    int fetch_seen = 0, mem_seen = 0, rf_seen = 0, we_bad = 0, exp_fetch;
    is_load_i = v.is_load; is_store_i = v.is_store; rd_we_i = v.rd_we;
    rd_idx_i = v.rd_idx; pc_next_i = v.pc_next;
    trace.delete();
    check($sformatf("v%0d.addr", id), inst_addr_o, m_pc);
    for (int c = 0; c < v.exp_cycles; c++) begin
      trace.push_back(state_o);
      if (rf_we_o) rf_seen++;
      if (data_req_o && (data_we_o != v.is_store)) we_bad++;
      if (inst_req_o) begin
        inst_ack_i   = (fetch_seen == v.inst_wait);
        inst_rdata_i = inst_ack_i ? v.inst : $urandom;
        fetch_seen++;
      end else begin
        inst_ack_i   = ($urandom_range(0, 3) == 0);
        inst_rdata_i = $urandom;
      end
      if (data_req_o) begin
        data_ack_i   = (mem_seen == v.data_wait);
        data_rdata_i = data_ack_i ? v.rdata : $urandom;
        mem_seen++;
      end else begin
        data_ack_i   = ($urandom_range(0, 3) == 0);
        data_rdata_i = $urandom;
      end
      @(negedge clk);
    end
    inst_ack_i = 1'b0; data_ack_i = 1'b0;

    exp_fetch = (v.inst_wait < TIMEOUT) ? v.inst_wait + 1 : TIMEOUT;
    m_mcycle += 32'(v.exp_cycles);
    if (v.inst_wait < TIMEOUT) m_ir = v.inst;
    if (v.is_load && !v.is_store && v.inst_wait < TIMEOUT && v.data_wait < TIMEOUT) m_mdr = v.rdata;
    if (!v.exp_err) begin
      m_pc = v.pc_next;
      m_instret += 32'd1;
    end

    check($sformatf("v%0d.state", id),   state_o,   v.exp_err ? 3'd7 : 3'd0);
    check($sformatf("v%0d.err", id),     err_o,     v.exp_err);
    check($sformatf("v%0d.pc", id),      pc_o,      m_pc);
    check($sformatf("v%0d.instret", id), instret_o, m_instret);
    check($sformatf("v%0d.mcycle", id),  mcycle_o,  m_mcycle);
    check($sformatf("v%0d.ir", id),      ir_o,      m_ir);
    check($sformatf("v%0d.mdr", id),     mdr_o,     m_mdr);
    check($sformatf("v%0d.fetch", id),   fetch_seen, exp_fetch);
    check($sformatf("v%0d.memreq", id),  mem_seen,  v.exp_mem);
    check($sformatf("v%0d.rfwe", id),    rf_seen,   v.exp_rf_we);
    check($sformatf("v%0d.we", id),      we_bad,    0);
    if (v.exp_err) begin
      inst_ack_i = 1'b1; data_ack_i = 1'b1;
      repeat (3) @(negedge clk);
      inst_ack_i = 1'b0; data_ack_i = 1'b0;
      check($sformatf("v%0d.frozen", id), mcycle_o, m_mcycle);
      check($sformatf("v%0d.errhold", id), {state_o, inst_req_o, data_req_o, rf_we_o, err_o}, 7'b111_0001);
    end
  endtask

  vec_t dir[6];
  vec_t err_vec[3];
  vec_t rv;
  logic [31:0] r;
  logic [2:0]  alu_trace[4];

  initial begin
    rst = 1'b0; inst_ack_i = 1'b0; data_ack_i = 1'b0; inst_rdata_i = '0; data_rdata_i = '0;
    is_load_i = 1'b0; is_store_i = 1'b0; rd_we_i = 1'b0; rd_idx_i = '0; pc_next_i = '0;

    //            ld st we rd   pc_next       iw dw rdata         cyc mem rf err
    dir[0] = mk(0, 0, 1, 5'd5, 32'h104, 0, 0, 32'h0,         4, 0, 1, 0);
    dir[1] = mk(1, 0, 1, 5'd6, 32'h108, 0, 3, 32'hDEADBEEF,  8, 4, 1, 0);
    dir[2] = mk(0, 0, 1, 5'd0, 32'h200, 0, 0, 32'h0,         4, 0, 0, 0);
    dir[3] = mk(0, 1, 0, 5'd9, 32'h204, 2, 1, 32'h1234_5678, 8, 2, 0, 0);
    dir[4] = mk(1, 1, 1, 5'd7, 32'h208, 0, 0, 32'hCAFE_F00D, 5, 1, 1, 0);
    dir[5] = mk(0, 0, 1, 5'd3, 32'h20C, 3, 0, 32'h0,         7, 0, 1, 0);
    err_vec[0] = mk(0, 0, 1, 5'd4, 32'h102, 0, 0, 32'h0,     4, 0, 0, 1);
    err_vec[1] = mk(0, 0, 1, 5'd4, 32'h104, 10, 0, 32'h0,    4, 0, 0, 1);
    err_vec[2] = mk(1, 0, 1, 5'd4, 32'h104, 0, 9, 32'h0,     7, 4, 0, 1);
    alu_trace[0] = 3'd0; alu_trace[1] = 3'd1; alu_trace[2] = 3'd2; alu_trace[3] = 3'd4;

    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_vec(dir[i], i);
      if (i == 0)
        for (int k = 0; k < 4; k++) check($sformatf("alu.trace%0d", k), trace[k], alu_trace[k]);
    end

    // Reset asserted mid-MEM with a pending load; a late ack must be ignored.
    is_load_i = 1'b1; is_store_i = 1'b0; rd_we_i = 1'b1; rd_idx_i = 5'd2; pc_next_i = 32'h300;
    inst_ack_i = 1'b1; inst_rdata_i = 32'h0000_2003;
    @(negedge clk); inst_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    check("midmem.req", data_req_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midmem.drop", {data_req_o, inst_req_o}, 2'b00);
    check("midmem.state", state_o, 3'd0);
    check("midmem.pc", pc_o, RESET_PC);
    @(negedge clk);
    rst = 1'b1; data_ack_i = 1'b1; data_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    data_ack_i = 1'b0;
    check("post.state", state_o, 3'd0);
    check("post.pc", pc_o, RESET_PC);
    check("post.mdr", mdr_o, 32'd0);
    check("post.req", inst_req_o, 1'b1);

    for (int i = 0; i < 3; i++) begin
      do_reset();
      run_vec(err_vec[i], 10 + i);
    end

    do_reset();
    for (int i = 0; i < 60; i++) begin
      rv.is_load   = ($urandom_range(0, 2) == 0);
      rv.is_store  = ($urandom_range(0, 3) == 0);
      rv.rd_we     = $urandom_range(0, 1);
      rv.rd_idx    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r            = $urandom;
      rv.pc_next   = ($urandom_range(0, 9) == 0) ? (r | 32'h1) : (r & ~32'h3);
      rv.inst      = $urandom;
      rv.rdata     = $urandom;
      rv.inst_wait = ($urandom_range(0, 11) == 0) ? 6 : $urandom_range(0, 3);
      rv.data_wait = ($urandom_range(0, 11) == 0) ? 5 : $urandom_range(0, 3);
      rv = predict(rv);
      run_vec(rv, 100 + i);
      if (rv.exp_err) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
